// File: rtl/flash_seq_if.sv
// Request, stream and SPI-flash-wrapper signals of the flash_seq byte-burst sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface flash_seq_if #(
  parameter int unsigned LEN_W = 10
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             done;
  logic             err;
  logic             fls_start_n;
  logic [2:0]       fls_mod_sel;
  logic [23:0]      fls_addr;
  logic [7:0]       fls_write;
  logic [7:0]       fls_read;
  logic             fls_busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_len, wr_data, wr_valid, rd_ready, fls_read, fls_busy,
    output req_ready, wr_ready, rd_data, rd_valid, done, err,
           fls_start_n, fls_mod_sel, fls_addr, fls_write
  );

  modport master (
    output req_valid, req_op, req_addr, req_len, wr_data, wr_valid, rd_ready, fls_read, fls_busy,
    input  req_ready, wr_ready, rd_data, rd_valid, done, err,
           fls_start_n, fls_mod_sel, fls_addr, fls_write
  );
endinterface

// File: rtl/flash_seq.sv
// Byte-burst sequencer in front of the SPI flash wrapper: one start pulse per byte operation,
// reads streamed out on rd_*, program bytes taken on wr_* and committed via WREN -> PROG -> RDSR polling.
module flash_seq #(
  parameter int unsigned LEN_W    = 10,
  parameter int unsigned BUSY_TO  = 16,
  parameter int unsigned POLL_MAX = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  flash_seq_if.slave  bus
);

  localparam logic [2:0] MOD_READ = 3'd0;
  localparam logic [2:0] MOD_WREN = 3'd1;
  localparam logic [2:0] MOD_PROG = 3'd2;
  localparam logic [2:0] MOD_RDSR = 3'd3;

  localparam int unsigned TMR_W  = $clog2(BUSY_TO + 1);
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_WR  = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_EVAL    = 3'd5;
  localparam logic [2:0] S_RD_OUT  = 3'd6;
  localparam logic [2:0] S_NEXT    = 3'd7;

  localparam logic [1:0] PH_WREN = 2'd0;
  localparam logic [1:0] PH_PROG = 2'd1;
  localparam logic [1:0] PH_RDSR = 2'd2;

  logic [2:0]        r_state;
  logic              r_op;
  logic [23:0]       r_cur_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic [1:0]        r_phase;
  logic [7:0]        r_wbyte;
  logic [TMR_W-1:0]  r_timer;
  logic              r_seen_lo;
  logic [POLL_W-1:0] r_polls;
  logic              r_req_ready;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic [7:0]        r_rd_data;
  logic              r_done;
  logic              r_err;
  logic              r_fls_start_n;
  logic [2:0]        r_fls_mod_sel;
  logic [23:0]       r_fls_addr;
  logic [7:0]        r_fls_write;

  logic [2:0]        w_state_nxt;
  logic              w_op_nxt;
  logic [23:0]       w_cur_addr_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic [1:0]        w_phase_nxt;
  logic [7:0]        w_wbyte_nxt;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic              w_seen_lo_nxt;
  logic [POLL_W-1:0] w_polls_nxt;
  logic              w_req_ready_nxt;
  logic              w_wr_ready_nxt;
  logic              w_rd_valid_nxt;
  logic [7:0]        w_rd_data_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_start_n_nxt;
  logic [2:0]        w_mod_sel_nxt;
  logic [23:0]       w_fls_addr_nxt;
  logic [7:0]        w_fls_write_nxt;
  logic              w_accept;

  assign w_accept = bus.req_valid & r_req_ready & (r_state == S_IDLE);

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_cur_addr_nxt  = r_cur_addr;
    w_cnt_nxt       = r_cnt;
    w_phase_nxt     = r_phase;
    w_wbyte_nxt     = r_wbyte;
    w_timer_nxt     = r_timer;
    w_seen_lo_nxt   = r_seen_lo;
    w_polls_nxt     = r_polls;
    w_rd_valid_nxt  = r_rd_valid;
    w_rd_data_nxt   = r_rd_data;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_mod_sel_nxt   = r_fls_mod_sel;
    w_fls_addr_nxt  = r_fls_addr;
    w_fls_write_nxt = r_fls_write;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt       = bus.req_op;
          w_cur_addr_nxt = bus.req_addr;
          w_cnt_nxt      = bus.req_len;
          w_err_nxt      = 1'b0;
          if (bus.req_len == '0) begin
            w_done_nxt = 1'b1;
          end else if (bus.req_op) begin
            w_state_nxt = S_GET_WR;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_GET_WR: begin
        if (bus.wr_valid && r_wr_ready) begin
          w_wbyte_nxt = bus.wr_data;
          w_phase_nxt = PH_WREN;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A busy line already high here is stale; the rise only counts after a low sample.
        w_state_nxt   = S_WAIT_HI;
        w_timer_nxt   = '0;
        w_seen_lo_nxt = ~bus.fls_busy;
      end
      S_WAIT_HI: begin
        if (bus.fls_busy && r_seen_lo) begin
          w_state_nxt = S_WAIT_LO;
        end else if (r_timer == TMR_W'(BUSY_TO - 1)) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
          if (!bus.fls_busy) w_seen_lo_nxt = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.fls_busy) w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (!r_op) begin
          w_rd_data_nxt  = bus.fls_read;
          w_rd_valid_nxt = 1'b1;
          w_state_nxt    = S_RD_OUT;
        end else begin
          case (r_phase)
            PH_WREN: begin
              w_phase_nxt = PH_PROG;
              w_state_nxt = S_ISSUE;
            end
            PH_PROG: begin
              w_phase_nxt = PH_RDSR;
              w_polls_nxt = POLL_W'(1);
              w_state_nxt = S_ISSUE;
            end
            default: begin
              if (!bus.fls_read[0]) begin
                w_state_nxt = S_NEXT;
              end else if (r_polls == POLL_W'(POLL_MAX)) begin
                w_state_nxt = S_IDLE;
                w_err_nxt   = 1'b1;
                w_done_nxt  = 1'b1;
              end else begin
                w_polls_nxt = r_polls + POLL_W'(1);
                w_state_nxt = S_ISSUE;
              end
            end
          endcase
        end
      end
      S_RD_OUT: begin
        if (bus.rd_ready) begin
          w_rd_valid_nxt = 1'b0;
          w_state_nxt    = S_NEXT;
        end
      end
      S_NEXT: begin
        w_cur_addr_nxt = r_cur_addr + 24'd1;
        w_cnt_nxt      = r_cnt - LEN_W'(1);
        if (r_cnt == LEN_W'(1)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_op) begin
          w_state_nxt = S_GET_WR;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_req_ready_nxt = (w_state_nxt == S_IDLE) && !w_accept && !bus.fls_busy;
    w_wr_ready_nxt  = (w_state_nxt == S_GET_WR);
    w_start_n_nxt   = (w_state_nxt != S_ISSUE);

    // Wrapper inputs only change together with a start pulse, so they hold for the whole op.
    if (w_state_nxt == S_ISSUE) begin
      w_fls_addr_nxt  = w_cur_addr_nxt;
      w_fls_write_nxt = w_wbyte_nxt;
      if (!w_op_nxt) begin
        w_mod_sel_nxt = MOD_READ;
      end else begin
        case (w_phase_nxt)
          PH_WREN: w_mod_sel_nxt = MOD_WREN;
          PH_PROG: w_mod_sel_nxt = MOD_PROG;
          default: w_mod_sel_nxt = MOD_RDSR;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= 1'b0;
      r_cur_addr    <= '0;
      r_cnt         <= '0;
      r_phase       <= PH_WREN;
      r_wbyte       <= '0;
      r_timer       <= '0;
      r_seen_lo     <= 1'b0;
      r_polls       <= '0;
      r_req_ready   <= 1'b0;
      r_wr_ready    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_fls_start_n <= 1'b1;
      r_fls_mod_sel <= '0;
      r_fls_addr    <= '0;
      r_fls_write   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_op          <= w_op_nxt;
      r_cur_addr    <= w_cur_addr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_phase       <= w_phase_nxt;
      r_wbyte       <= w_wbyte_nxt;
      r_timer       <= w_timer_nxt;
      r_seen_lo     <= w_seen_lo_nxt;
      r_polls       <= w_polls_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_wr_ready    <= w_wr_ready_nxt;
      r_rd_valid    <= w_rd_valid_nxt;
      r_rd_data     <= w_rd_data_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_fls_start_n <= w_start_n_nxt;
      r_fls_mod_sel <= w_mod_sel_nxt;
      r_fls_addr    <= w_fls_addr_nxt;
      r_fls_write   <= w_fls_write_nxt;
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.wr_ready    = r_wr_ready;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.rd_data     = r_rd_data;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.fls_start_n = r_fls_start_n;
  assign bus.fls_mod_sel = r_fls_mod_sel;
  assign bus.fls_addr    = r_fls_addr;
  assign bus.fls_write   = r_fls_write;

endmodule

// File: tb/tb_flash_seq.sv
// Self-checking bench for flash_seq: a behavioural SPI-flash wrapper model plus directed and
// randomized bursts compared against expected operation lists and byte streams.
module tb_flash_seq;

  localparam int unsigned BUSY_TO = 16;
  localparam int unsigned TB_POLL = 8;
  localparam logic [2:0] MOD_READ = 3'd0;
  localparam logic [2:0] MOD_WREN = 3'd1;
  localparam logic [2:0] MOD_PROG = 3'd2;
  localparam logic [2:0] MOD_RDSR = 3'd3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flash_seq_if #(.LEN_W(10)) bus ();

  flash_seq #(.LEN_W(10), .BUSY_TO(BUSY_TO), .POLL_MAX(TB_POLL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Wrapper model state and stimulus knobs
  logic        force_busy = 1'b1;
  logic        m_nobusy   = 1'b0;
  int          m_rise     = 1;
  int          m_b        = 2;
  logic        m_busy     = 1'b0;
  logic        m_act      = 1'b0;
  int          m_t        = 0;
  logic [2:0]  m_op       = 3'd0;
  logic [23:0] m_addr     = 24'd0;
  logic [7:0]  m_read     = 8'd0;
  logic [7:0]  mem [logic [23:0]];
  logic [7:0]  stat_mem [0:63];
  int          stat_cnt   = 0;
  int          stat_lim   = 0;
  logic [34:0] op_log [$];
  int          start_cyc  = 0;

  // Monitor state
  int          cyc        = 0;
  int          n_done     = 0;
  int          done_cyc   = 0;
  int          pulse_viol = 0;
  int          stab_viol  = 0;
  int          hold_viol  = 0;
  logic        p_start_n  = 1'b1;
  logic [34:0] p_fls      = '0;
  logic        p_valid    = 1'b0;
  logic        p_ready    = 1'b0;
  logic [7:0]  p_data     = 8'd0;

  logic [7:0]  pg_data [$];
  int          pg_poll [$];

  assign bus.fls_busy = m_busy | force_busy;
  assign bus.fls_read = m_read;

  // Wrapper: busy rises m_rise clocks after the start pulse, stays high m_b clocks, result valid at fall.
  always @(posedge clk) begin
    if (bus.fls_start_n === 1'b0) begin
      op_log.push_back({bus.fls_mod_sel, bus.fls_addr, bus.fls_write});
      start_cyc <= cyc;
      if (!m_nobusy) begin
        m_act  <= 1'b1;
        m_t    <= 1;
        m_op   <= bus.fls_mod_sel;
        m_addr <= bus.fls_addr;
      end
    end else if (m_act) begin
      m_t <= m_t + 1;
      if (m_t == m_rise) m_busy <= 1'b1;
      if (m_t == m_rise + m_b) begin
        m_busy <= 1'b0;
        m_act  <= 1'b0;
        if (m_op == MOD_READ) begin
          m_read <= mem[m_addr];
        end else if (m_op == MOD_RDSR) begin
          m_read   <= (stat_cnt < stat_lim) ? stat_mem[stat_cnt % 64] : 8'h00;
          stat_cnt <= stat_cnt + 1;
        end else begin
          m_read <= 8'($urandom);
        end
      end
    end
  end

  // Protocol monitor: done count, start-pulse width, wrapper-input stability, rd hold.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done === 1'b1) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (rst_n === 1'b1) begin
      if (!bus.fls_start_n && !p_start_n) pulse_viol <= pulse_viol + 1;
      if (bus.fls_start_n && p_start_n && (m_act || m_busy) &&
          ({bus.fls_mod_sel, bus.fls_addr, bus.fls_write} != p_fls)) stab_viol <= stab_viol + 1;
      if (p_valid && !p_ready && (!bus.rd_valid || bus.rd_data != p_data)) hold_viol <= hold_viol + 1;
    end
    p_start_n <= bus.fls_start_n;
    p_fls     <= {bus.fls_mod_sel, bus.fls_addr, bus.fls_write};
    p_valid   <= bus.rd_valid;
    p_ready   <= bus.rd_ready;
    p_data    <= bus.rd_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (bus.req_ready !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("req_ready_wait", 64'(bus.req_ready), 64'(1));
  endtask

  task automatic send_req(input logic op, input logic [23:0] addr, input logic [9:0] len);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_len   = len;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 24'($urandom);
  endtask

  // Read burst; byte stall_idx is back-pressured for stall_cyc cycles.
  task automatic run_read(input logic [23:0] addr, input int len, input int stall_idx,
                          input int stall_cyc, input bit preset);
    int base_ops  = op_log.size();
    int base_done = n_done;
    int k = 0, st = 0, guard = 0, ops_stall = 0, ops_after = 0;
    bit fin = 0;
    logic [7:0] got [$];
    if (!preset) for (int i = 0; i < len; i++) mem[24'(addr + 24'(i))] = 8'($urandom);
    send_req(1'b0, addr, 10'(len));
    while (!fin && guard < 4000) begin
      if (bus.rd_valid === 1'b1) begin
        if (k == stall_idx && st < stall_cyc) begin
          if (st == 0) ops_stall = op_log.size();
          bus.rd_ready = 1'b0;
          st++;
        end else begin
          if (k == stall_idx && stall_cyc > 0) ops_after = op_log.size();
          bus.rd_ready = 1'b1;
          got.push_back(bus.rd_data);
          k++;
        end
      end else begin
        bus.rd_ready = 1'($urandom_range(0, 1));
      end
      if (bus.done === 1'b1) fin = 1;
      @(negedge clk);
      guard++;
    end
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd_done_seen", 64'(fin), 64'(1));
    chk("rd_byte_count", 64'(got.size()), 64'(len));
    for (int i = 0; i < got.size() && i < len; i++)
      chk("rd_data", 64'(got[i]), 64'(mem[24'(addr + 24'(i))]));
    chk("rd_op_count", 64'(op_log.size() - base_ops), 64'(len));
    for (int i = base_ops; i < op_log.size() && i < base_ops + len; i++)
      chk("rd_op_mod_addr", 64'(op_log[i][34:8]), 64'({MOD_READ, 24'(addr + 24'(i - base_ops))}));
    chk("rd_done_pulses", 64'(n_done - base_done), 64'(1));
    chk("rd_err", 64'(bus.err), 64'(0));
    if (stall_cyc > 0) chk("rd_no_op_while_stalled", 64'(ops_after - ops_stall), 64'(0));
  endtask

  // Program burst of pg_data bytes; byte i sees pg_poll[i] RDSR polls (last one clears WIP).
  task automatic run_prog(input logic [23:0] addr, input bit poll_fail);
    int len = pg_data.size();
    int base_ops = op_log.size();
    int base_done = n_done;
    int s = stat_cnt, nst = 0, k = 0, guard = 0;
    bit fin = 0;
    logic [2:0]  e_mod  [$];
    logic [23:0] e_addr [$];
    logic [7:0]  e_wr   [$];
    if (poll_fail) begin
      for (int j = 0; j < 20; j++) stat_mem[(s + j) % 64] = 8'($urandom) | 8'h01;
      nst = 20;
      e_mod.push_back(MOD_WREN); e_addr.push_back(addr); e_wr.push_back(pg_data[0]);
      e_mod.push_back(MOD_PROG); e_addr.push_back(addr); e_wr.push_back(pg_data[0]);
      for (int j = 0; j < TB_POLL; j++) begin
        e_mod.push_back(MOD_RDSR); e_addr.push_back(addr); e_wr.push_back(pg_data[0]);
      end
    end else begin
      for (int i = 0; i < len; i++) begin
        e_mod.push_back(MOD_WREN); e_addr.push_back(24'(addr + 24'(i))); e_wr.push_back(pg_data[i]);
        e_mod.push_back(MOD_PROG); e_addr.push_back(24'(addr + 24'(i))); e_wr.push_back(pg_data[i]);
        for (int j = 0; j < pg_poll[i]; j++) begin
          stat_mem[(s + nst) % 64] = (j == pg_poll[i] - 1) ? (8'($urandom) & 8'hFE)
                                                           : (8'($urandom) | 8'h01);
          nst++;
          e_mod.push_back(MOD_RDSR); e_addr.push_back(24'(addr + 24'(i))); e_wr.push_back(pg_data[i]);
        end
      end
    end
    stat_lim = s + nst;
    send_req(1'b1, addr, 10'(len));
    while (!fin && guard < 8000) begin
      if (bus.wr_ready === 1'b1 && k < len && $urandom_range(0, 2) != 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = pg_data[k];
        k++;
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'($urandom);
      end
      if (bus.done === 1'b1) fin = 1;
      @(negedge clk);
      guard++;
    end
    bus.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pg_done_seen", 64'(fin), 64'(1));
    chk("pg_op_count", 64'(op_log.size() - base_ops), 64'(e_mod.size()));
    for (int i = 0; i < e_mod.size() && base_ops + i < op_log.size(); i++) begin
      chk("pg_op_mod", 64'(op_log[base_ops + i][34:32]), 64'(e_mod[i]));
      if (e_mod[i] == MOD_PROG)
        chk("pg_prog_addr_data", 64'(op_log[base_ops + i][31:0]), 64'({e_addr[i], e_wr[i]}));
    end
    chk("pg_done_pulses", 64'(n_done - base_done), 64'(1));
    chk("pg_err", 64'(bus.err), 64'(poll_fail));
  endtask

  initial begin
    int base_ops, base_done, g;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values with the wrapper busy
    chk("rst_ready_flags", 64'({bus.req_ready, bus.wr_ready, bus.rd_valid, bus.done, bus.err}), 64'(0));
    chk("rst_rd_data", 64'(bus.rd_data), 64'(0));
    chk("rst_start_n", 64'(bus.fls_start_n), 64'(1));
    chk("rst_fls_bus", 64'({bus.fls_mod_sel, bus.fls_addr, bus.fls_write}), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_after_rst_not_ready", 64'(bus.req_ready), 64'(0));
    end
    force_busy = 1'b0;
    wait_ready();

    // Directed read A0,A1,A2 at 0x100
    mem[24'h000100] = 8'hA0; mem[24'h000101] = 8'hA1; mem[24'h000102] = 8'hA2;
    run_read(24'h000100, 3, -1, 0, 1'b1);
    // Same read with byte 2 back-pressured for 10 clocks
    run_read(24'h000100, 3, 1, 10, 1'b1);

    // Program 5A,C3 at 0xFE; byte 1 polls 01,01,00
    pg_data = '{8'h5A, 8'hC3};
    pg_poll = '{3, 1};
    run_prog(24'h0000FE, 1'b0);

    // Address wrap
    mem[24'hFFFFFF] = 8'h3C; mem[24'h000000] = 8'hC5;
    run_read(24'hFFFFFF, 2, -1, 0, 1'b1);

    // Zero-length request: done, no start pulse
    base_ops  = op_log.size();
    base_done = n_done;
    send_req(1'b0, 24'h001234, 10'd0);
    repeat (3) @(negedge clk);
    chk("len0_no_op", 64'(op_log.size() - base_ops), 64'(0));
    chk("len0_done", 64'(n_done - base_done), 64'(1));
    chk("len0_err", 64'(bus.err), 64'(0));

    // Busy never rises: timeout, single op, remaining bytes dropped
    m_nobusy  = 1'b1;
    base_ops  = op_log.size();
    base_done = n_done;
    send_req(1'b0, 24'h000400, 10'd3);
    g = 0;
    while (bus.done !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("to_done_seen", 64'(bus.done), 64'(1));
    repeat (4) @(negedge clk);
    chk("to_err_sticky", 64'(bus.err), 64'(1));
    chk("to_single_op", 64'(op_log.size() - base_ops), 64'(1));
    chk("to_done_pulses", 64'(n_done - base_done), 64'(1));
    chk("to_latency_window", 64'((done_cyc - start_cyc) >= int'(BUSY_TO) &&
                                 (done_cyc - start_cyc) <= int'(BUSY_TO) + 3), 64'(1));
    m_nobusy = 1'b0;

    // Randomized reads with varied wrapper timing and back-pressure (also clears err)
    for (int t = 0; t < 4; t++) begin
      m_rise = $urandom_range(1, 3);
      m_b    = $urandom_range(1, 4);
      run_read(24'($urandom), $urandom_range(1, 5), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
    end

    // Randomized programs
    for (int t = 0; t < 3; t++) begin
      int n;
      m_rise = $urandom_range(1, 3);
      m_b    = $urandom_range(1, 4);
      n      = $urandom_range(1, 3);
      pg_data.delete();
      pg_poll.delete();
      for (int i = 0; i < n; i++) begin
        pg_data.push_back(8'($urandom));
        pg_poll.push_back($urandom_range(1, 3));
      end
      run_prog(24'($urandom), 1'b0);
    end

    // WIP never clears: poll limit timeout on first byte
    pg_data = '{8'h11, 8'h22};
    pg_poll = '{1, 1};
    run_prog(24'h00A000, 1'b1);

    chk("start_pulse_width", 64'(pulse_viol), 64'(0));
    chk("fls_inputs_stable", 64'(stab_viol), 64'(0));
    chk("rd_valid_held", 64'(hold_viol), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
